// File: rtl/pc_ras.sv
// Fetch program counter with jump/branch/call/return and a circular return-address stack; one-cycle update, stall holds all state.
// Optional PC_RAS_ERR_EN adds a sticky ras_err flag for stack underflow/overflow.
module pc_ras #(
  parameter int D = 12,
  parameter int O = 8,
  parameter int S = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 absjump_en,
  input  logic                 reljump_en,
  input  logic                 call_en,
  input  logic                 ret_en,
  input  logic [D-1:0]         target,
  input  logic [O-1:0]         offset,
  output logic [D-1:0]         prog_ctr,
  output logic [$clog2(S):0]   ras_depth,
  output logic                 ras_empty,
`ifdef PC_RAS_ERR_EN
  output logic                 ras_err,
`endif
  output logic                 ras_full
);

  localparam int PW = $clog2(S);
  localparam int DW = PW + 1;

  logic [D-1:0]  pc_q, pc_d;
  logic [D-1:0]  stack_q [S];
  logic [D-1:0]  stack_d [S];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [D-1:0]  pc_inc;
  logic [D-1:0]  off_ext;
  logic [PW-1:0] ptr_dec;
  logic          empty, full;

  assign pc_inc  = pc_q + D'(1);
  assign off_ext = D'($signed(offset));
  assign ptr_dec = ptr_q - PW'(1);
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DW'(S));

`ifdef PC_RAS_ERR_EN
  logic err_q, err_d;
`endif

  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
`ifdef PC_RAS_ERR_EN
    err_d   = err_q;
`endif
    if (!stall) begin
      if (ret_en) begin
        if (!empty) begin
          pc_d    = stack_q[ptr_dec];
          ptr_d   = ptr_dec;
          depth_d = depth_q - DW'(1);
        end else begin
          // Underflow behaves as a plain increment; lower requests still lose.
          pc_d = pc_inc;
`ifdef PC_RAS_ERR_EN
          err_d = 1'b1;
`endif
        end
      end else if (call_en) begin
        // When full, ptr_q already points at the oldest entry, so the push overwrites it.
        stack_d[ptr_q] = pc_inc;
        ptr_d          = ptr_q + PW'(1);
        pc_d           = target;
        if (!full) begin
          depth_d = depth_q + DW'(1);
        end
`ifdef PC_RAS_ERR_EN
        else begin
          err_d = 1'b1;
        end
`endif
      end else if (absjump_en) begin
        pc_d = target;
      end else if (reljump_en) begin
        pc_d = pc_q + off_ext;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      for (int i = 0; i < S; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
    end
  end

`ifdef PC_RAS_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ras_err = err_q;
`endif

  assign prog_ctr  = pc_q;
  assign ras_depth = depth_q;
  assign ras_empty = empty;
  assign ras_full  = full;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras with hand-computed expectations (D=12, O=8, S=4).
module tb_pc_ras;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        absjump_en;
  logic        reljump_en;
  logic        call_en;
  logic        ret_en;
  logic [11:0] target;
  logic [7:0]  offset;
  logic [11:0] prog_ctr;
  logic [2:0]  ras_depth;
  logic        ras_empty;
  logic        ras_full;
`ifdef PC_RAS_ERR_EN
  logic        ras_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pc_ras #(.D(12), .O(8), .S(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .absjump_en (absjump_en),
    .reljump_en (reljump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .target     (target),
    .offset     (offset),
    .prog_ctr   (prog_ctr),
    .ras_depth  (ras_depth),
    .ras_empty  (ras_empty),
`ifdef PC_RAS_ERR_EN
    .ras_err    (ras_err),
`endif
    .ras_full   (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of controls, then return them to idle.
  task automatic cyc(input logic r, input logic c, input logic a, input logic j,
                     input logic [11:0] t, input logic [7:0] o);
    ret_en     = r;
    call_en    = c;
    absjump_en = a;
    reljump_en = j;
    target     = t;
    offset     = o;
    step();
    ret_en     = 1'b0;
    call_en    = 1'b0;
    absjump_en = 1'b0;
    reljump_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    absjump_en = 1'b0; reljump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    target = '0; offset = '0;
    #12;
    chk("rst_pc", 32'(prog_ctr), 32'h000);
    chk("rst_depth", 32'(ras_depth), 32'd0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
`ifdef PC_RAS_ERR_EN
    chk("rst_err", 32'(ras_err), 32'd0);
`endif
    reset = 1'b0;
    step(); step(); step();
    chk("inc3", 32'(prog_ctr), 32'h003);

    // Asynchronous assertion between edges.
    #2 reset = 1'b1;
    #1 chk("async_rst", 32'(prog_ctr), 32'h000);
    reset = 1'b0;
    step();
    chk("post_rst_inc", 32'(prog_ctr), 32'h001);

    cyc(0, 0, 1, 0, 12'hFFF, 8'h00);
    chk("abs_fff", 32'(prog_ctr), 32'hFFF);
    step();
    chk("wrap", 32'(prog_ctr), 32'h000);

    // Relative branches.
    cyc(0, 0, 1, 0, 12'h010, 8'h00);
    cyc(0, 0, 0, 1, 12'h000, 8'hFC);
    chk("rel_m4", 32'(prog_ctr), 32'h00C);
    cyc(0, 0, 0, 1, 12'h000, 8'h05);
    chk("rel_p5", 32'(prog_ctr), 32'h011);
    cyc(0, 0, 1, 0, 12'h002, 8'h00);
    cyc(0, 0, 0, 1, 12'h000, 8'hFC);
    chk("rel_wrap", 32'(prog_ctr), 32'hFFE);
    cyc(0, 0, 0, 1, 12'h000, 8'h00);
    chk("rel_zero", 32'(prog_ctr), 32'hFFE);

    // Nested call/return.
    cyc(0, 0, 1, 0, 12'h020, 8'h00);
    cyc(0, 1, 0, 0, 12'h100, 8'h00);
    chk("call1_pc", 32'(prog_ctr), 32'h100);
    chk("call1_dep", 32'(ras_depth), 32'd1);
    cyc(0, 1, 0, 0, 12'h200, 8'h00);
    chk("call2_pc", 32'(prog_ctr), 32'h200);
    chk("call2_dep", 32'(ras_depth), 32'd2);
    cyc(1, 0, 0, 0, 12'h000, 8'h00);
    chk("ret1_pc", 32'(prog_ctr), 32'h101);
    chk("ret1_dep", 32'(ras_depth), 32'd1);
    cyc(1, 0, 0, 0, 12'h000, 8'h00);
    chk("ret2_pc", 32'(prog_ctr), 32'h021);
    chk("ret2_dep", 32'(ras_depth), 32'd0);
    chk("ret2_empty", 32'(ras_empty), 32'd1);

    // Overflow: five calls into a four-deep stack.
    cyc(0, 0, 1, 0, 12'h000, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 0, 0, 12'(i * 16), 8'h00);
      if (i == 4) chk("full_at4", 32'(ras_full), 32'd1);
`ifdef PC_RAS_ERR_EN
      if (i == 4) chk("err_pre_ovf", 32'(ras_err), 32'd0);
`endif
    end
    chk("ovf_pc", 32'(prog_ctr), 32'h050);
    chk("ovf_dep", 32'(ras_depth), 32'd4);
    chk("ovf_full", 32'(ras_full), 32'd1);
`ifdef PC_RAS_ERR_EN
    chk("err_ovf", 32'(ras_err), 32'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 12'h000, 8'h00);
      chk($sformatf("ovf_ret%0d", i), 32'(prog_ctr), 32'h041 - 32'(i * 16));
    end
    chk("unwind_dep", 32'(ras_depth), 32'd0);
    cyc(1, 0, 0, 0, 12'h000, 8'h00);
    chk("udf_inc", 32'(prog_ctr), 32'h012);
    chk("udf_dep", 32'(ras_depth), 32'd0);
`ifdef PC_RAS_ERR_EN
    chk("err_sticky", 32'(ras_err), 32'd1);
`endif

    // Priority: ret beats call and absjump; no push.
    cyc(0, 0, 1, 0, 12'h054, 8'h00);
    cyc(0, 1, 0, 0, 12'h300, 8'h00);
    chk("pri_setup", 32'(ras_depth), 32'd1);
    cyc(1, 1, 1, 0, 12'h400, 8'h00);
    chk("pri_pc", 32'(prog_ctr), 32'h055);
    chk("pri_dep", 32'(ras_depth), 32'd0);
    // Underflowing ret still outranks absjump.
    cyc(1, 0, 1, 0, 12'h777, 8'h00);
    chk("pri_udf", 32'(prog_ctr), 32'h056);

    // Stall holds everything.
    cyc(0, 0, 1, 0, 12'h060, 8'h00);
    stall = 1'b1;
    cyc(0, 1, 0, 0, 12'h700, 8'h00);
    chk("stall_pc", 32'(prog_ctr), 32'h060);
    chk("stall_dep", 32'(ras_depth), 32'd0);
    cyc(1, 0, 0, 1, 12'h000, 8'h10);
    chk("stall_pc2", 32'(prog_ctr), 32'h060);
    stall = 1'b0;
    step();
    chk("unstall", 32'(prog_ctr), 32'h061);

    // Reset mid-operation with a call pending.
    cyc(0, 1, 0, 0, 12'h100, 8'h00);
    cyc(0, 1, 0, 0, 12'h200, 8'h00);
    cyc(0, 1, 0, 0, 12'h300, 8'h00);
    chk("mid_dep3", 32'(ras_depth), 32'd3);
    call_en = 1'b1;
    target  = 12'h400;
    #2 reset = 1'b1;
    #1;
    chk("mid_pc", 32'(prog_ctr), 32'h000);
    chk("mid_dep", 32'(ras_depth), 32'd0);
    step();
    chk("mid_hold_pc", 32'(prog_ctr), 32'h000);
    chk("mid_hold_empty", 32'(ras_empty), 32'd1);
`ifdef PC_RAS_ERR_EN
    chk("mid_err_clr", 32'(ras_err), 32'd0);
`endif
    call_en = 1'b0;
    reset   = 1'b0;
    step();
    chk("mid_post_pc", 32'(prog_ctr), 32'h001);
    chk("mid_post_dep", 32'(ras_depth), 32'd0);
    // Stack was cleared: ret on empty just increments.
    cyc(1, 0, 0, 0, 12'h000, 8'h00);
    chk("mid_ret_empty", 32'(prog_ctr), 32'h002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Next-generation program counter for the fetch stage.
- Supports absolute jumps, signed relative branches, subroutine call/return through an internal return-address stack (RAS), and fetch stall.
- Drives the instruction-memory address each cycle; control inputs come from the decode/control unit.

Parameters:
- D, 12, program counter width in bits.
- O, 8, width of the signed relative branch offset (O <= D).
- S, 4, return-address stack depth in entries (S >= 2, power of two).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold all state this cycle.
- absjump_en  input  1  absolute jump to target.
- reljump_en  input  1  relative branch by offset.
- call_en  input  1  jump to target; push return address.
- ret_en  input  1  pop return address into PC.
- target  input  D  absolute destination for absjump_en and call_en.
- offset  input  O  signed two's-complement branch offset.
- prog_ctr  output  D  current program counter.
- ras_depth  output  $clog2(S)+1  number of valid RAS entries, 0..S.
- ras_empty  output  1  ras_depth == 0.
- ras_full  output  1  ras_depth == S.

Behaviour:
- Reset: asynchronous, active-high. While reset=1 and on its assertion:
  - prog_ctr=0, ras_depth=0, ras_empty=1, ras_full=0.
  - RAS contents cleared to 0; stack pointer = 0.
  - Reset mid-operation discards any pending call/ret; first post-reset edge with no controls gives prog_ctr=1.
- Update priority per rising edge: reset > stall > ret_en > call_en > absjump_en > reljump_en > increment. Only the highest-priority active request takes effect; lower requests in the same cycle are ignored.
- stall=1: prog_ctr, RAS contents, pointer and depth all hold.
- ret_en:
  - Non-empty: prog_ctr <= top entry; pointer decrements; depth decrements.
  - Empty: treated as plain increment; RAS unchanged.
- call_en:
  - Push (prog_ctr + 1) mod 2^D; prog_ctr <= target.
  - If full: the push overwrites the oldest entry (circular pointer wrap) and depth stays at S.
- absjump_en: prog_ctr <= target.
- reljump_en: prog_ctr <= (prog_ctr + sign_extend(offset)) mod 2^D. Offset is relative to the current PC, not PC+1; offset=0 re-executes the same address.
- Default: prog_ctr <= (prog_ctr + 1) mod 2^D; 2^D-1 wraps to 0.
- Latency: one cycle. The new prog_ctr is visible after the edge that samples the request.
- Status outputs are combinational from registered depth; no extra latency.
- All arithmetic is unsigned modulo 2^D except the offset sign extension.

Optional Feature:
- Macro PC_RAS_ERR_EN.
- Defined: adds output ras_err (1 bit), reset 0. It is sticky, set on an edge that performs either:
  - ret_en with ras_empty=1 (underflow), or
  - call_en with ras_full=1 (overflow),
  and only when that request wins priority. Cleared only by reset. PC behaviour is identical to the undefined build.
- Undefined: no ras_err port and no related logic.

Test Plan:
- Reset/increment: assert reset asynchronously between edges -> prog_ctr=0 immediately; release, 3 edges -> prog_ctr=3; from 0xFFF, one edge -> 0x000.
- Relative branch: prog_ctr=0x010, offset=8'hFC, reljump_en -> 0x00C; offset=8'h05 -> 0x011; prog_ctr=0x002, offset=-4 -> 0xFFE.
- Call/return nesting: at 0x020 call target=0x100; at 0x100 call 0x200; ret -> 0x101; ret -> 0x021; depth sequence 1,2,1,0; ras_empty=1 at end.
- Overflow/underflow: 5 calls with S=4 from PCs 0x0,0x10,0x20,0x30,0x40 -> ras_full=1, depth=4, 4 rets return 0x41,0x31,0x21,0x11; 5th ret on empty -> prog_ctr increments; with PC_RAS_ERR_EN, ras_err=1 after the 5th call and stays 1.
- Priority/stall: ret_en+call_en+absjump_en together with top=0x055 -> prog_ctr=0x055, no push; stall=1 with call_en -> prog_ctr and depth unchanged.
- Reset mid-operation: depth=3, assert reset during call_en -> prog_ctr=0, depth=0, no push occurs.
